sipo_frame_ctrl: RTL

Framing controller that sequences a serial-in/parallel-out shift register, one bit per cycle.
- Detects a start bit on the serial line and enables shifting for exactly WIDTH bits.
- Checks the stop bit and hands the assembled word to a one-deep holding register with a valid/ready handshake.
- Sits between a raw serial input and any parallel consumer (display, register file, FIFO).

---
 rtl/sipo_frame_ctrl_pkg.sv | 14 +
 rtl/shift_sipo_en.sv | 25 ++
 rtl/sipo_frame_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the serial framing controller: FSM state encoding and line levels.
// The serial line idles high, so a low sample is a start bit and a high sample is a good stop bit.
package sipo_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_STOP  = 2'd2
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/shift_sipo_en.sv
// Right-shifting serial-in/parallel-out register; new bits enter at the MSB.
// Gated by i_shift_en; the first bit of a WIDTH-bit burst ends up in o_q[0].
module shift_sipo_en #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_shift_en,
   input  logic             i_s_in,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q <= '0;
      end else if (i_shift_en) begin
         r_q <= {i_s_in, r_q[WIDTH-1:1]};
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Start/stop framing around a SIPO shifter, delivering words through a one-deep valid/ready holding register.
// Start-to-valid latency WIDTH+2 cycles; a good frame arriving while the holder is full and unconsumed is dropped and flags overrun.
module sipo_frame_ctrl
   import sipo_frame_ctrl_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             s_in,
   input  logic             data_ready,
   input  logic             clr_ovr,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] w_shreg;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_frame_err;
   logic             r_overrun;
   logic             w_shift_en;
   logic             w_good_stop;
   logic             w_bad_stop;
   logic             w_load;
   logic             w_ovr_set;

   shift_sipo_en #(
      .WIDTH (WIDTH)
   ) u_shift (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_shift_en (w_shift_en),
      .i_s_in     (s_in),
      .o_q        (w_shreg)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Dropping en in SHIFT or STOP abandons the frame silently.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_good_stop = 1'b0;
      w_bad_stop  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en && (s_in == START_BIT)) begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!en) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_shift_en = 1'b1;
               if (r_cnt == LAST_CNT) begin
                  w_state_nxt = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            w_state_nxt = ST_IDLE;
            if (en) begin
               w_good_stop = (s_in == STOP_BIT);
               w_bad_stop  = (s_in != STOP_BIT);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_shift_en && (r_cnt != LAST_CNT)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   // A consume in the same cycle frees the slot, so the new word still loads.
   assign w_load    = w_good_stop && (!r_valid || data_ready);
   assign w_ovr_set = w_good_stop && r_valid && !data_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_load) begin
            r_data  <= w_shreg;
            r_valid <= 1'b1;
         end else if (r_valid && data_ready) begin
            r_valid <= 1'b0;
         end
         r_frame_err <= w_bad_stop;
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (clr_ovr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign busy       = (r_state != ST_IDLE);
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;

endmodule
